// File: rtl/prf_pkg.sv
// Shared types and constants for the PRF gate generator.
package prf_pkg;
  localparam int PRF_CNT_W      = 16;
  localparam int PRF_MIN_PERIOD = 4;

  typedef enum logic [2:0] {IDLE, TX, GAP, RX, TAIL} prf_state_t;
endpackage

// File: rtl/prf_cfg_clamp.sv
// Combinational clamp of raw PRF config into a self-consistent set plus an error flag.
module prf_cfg_clamp
  import prf_pkg::*;
#(
  parameter int CNT_W = PRF_CNT_W
) (
  input  logic [CNT_W-1:0] prf_period,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [CNT_W-1:0] rg_delay,
  input  logic [CNT_W-1:0] rg_len,
  output logic [CNT_W-1:0] p,
  output logic [CNT_W-1:0] l,
  output logic [CNT_W-1:0] d,
  output logic [CNT_W-1:0] r,
  output logic             err
);
  logic [CNT_W:0] d_end;

  always_comb begin
    p = (prf_period < CNT_W'(PRF_MIN_PERIOD)) ? CNT_W'(PRF_MIN_PERIOD) : prf_period;
    l = (burst_len > p) ? p : burst_len;
    // Receive window is pushed past the burst so it can never overlap transmit.
    d = (rg_delay < l) ? l : rg_delay;
    d_end = {1'b0, d} + {1'b0, rg_len};
    if (d >= p)                  r = '0;
    else if (d_end > {1'b0, p})  r = p - d;
    else                         r = rg_len;
    err = (p != prf_period) | (l != burst_len) | (d != rg_delay) | (r != rg_len);
  end
endmodule

// File: rtl/prf_gate_gen.sv
// PRF controller: per-period transmit gate, delayed receive window and period-start sync.
module prf_gate_gen
  import prf_pkg::*;
#(
  parameter int CNT_W = PRF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] prf_period,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [CNT_W-1:0] rg_delay,
  input  logic [CNT_W-1:0] rg_len,
  output logic             gate,
  output logic             rx_gate,
  output logic             prf_sync,
  output logic             busy,
  output logic             cfg_err
);
  prf_state_t       state, nxt_state;
  logic [CNT_W-1:0] pcnt, nxt_pcnt;
  logic [CNT_W-1:0] sp, sl, sd, sr;
  logic [CNT_W-1:0] cp, cl, cd, cr;
  logic             cerr, period_end, latch;

  prf_cfg_clamp #(.CNT_W(CNT_W)) u_clamp (
    .prf_period (prf_period),
    .burst_len  (burst_len),
    .rg_delay   (rg_delay),
    .rg_len     (rg_len),
    .p          (cp),
    .l          (cl),
    .d          (cd),
    .r          (cr),
    .err        (cerr)
  );

  // Region of the period a given count falls in; with R=0 everything past the burst is GAP.
  function automatic prf_state_t region(input logic [CNT_W-1:0] n, l, d, r);
    logic [CNT_W:0] e;
    e = {1'b0, d} + {1'b0, r};
    if (n < l)            return TX;
    if (r == '0)          return GAP;
    if (n < d)            return GAP;
    if ({1'b0, n} < e)    return RX;
    return TAIL;
  endfunction

  always_comb begin
    period_end = (state != IDLE) && (pcnt == sp - CNT_W'(1));
    latch      = enable && ((state == IDLE) || period_end);
    nxt_pcnt   = '0;
    nxt_state  = IDLE;
    if (latch) begin
      nxt_state = region({CNT_W{1'b0}}, cl, cd, cr);
    end else if ((state != IDLE) && !period_end) begin
      nxt_pcnt  = pcnt + CNT_W'(1);
      nxt_state = region(nxt_pcnt, sl, sd, sr);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pcnt     <= '0;
      sp       <= '0;
      sl       <= '0;
      sd       <= '0;
      sr       <= '0;
      gate     <= 1'b0;
      rx_gate  <= 1'b0;
      prf_sync <= 1'b0;
      busy     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= nxt_state;
      pcnt     <= nxt_pcnt;
      gate     <= (nxt_state == TX);
      rx_gate  <= (nxt_state == RX);
      prf_sync <= latch;
      busy     <= (nxt_state != IDLE);
      if (latch) begin
        sp      <= cp;
        sl      <= cl;
        sd      <= cd;
        sr      <= cr;
        cfg_err <= cerr;
      end else if (nxt_state == IDLE) begin
        cfg_err <= 1'b0;
      end
    end
  end
endmodule
